// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Length-prefixed little-endian byte stream to program-memory word
//            writer; holds the CPU in reset while a load is in progress.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int unsigned DEPTH          = 16384,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  output logic        WR_EN,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_DATA,
  output logic        CPU_RST,
  output logic        DONE,
  output logic        ERR
);

  localparam int unsigned c_WIDX_W = $clog2(DEPTH + 1);
  localparam logic [31:0] c_DEPTH  = 32'(DEPTH);
  localparam logic [31:0] c_TMO    = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                r_state;
  logic [1:0]            r_bcnt;
  logic [c_WIDX_W-1:0]   r_widx;
  logic [31:0]           r_len;
  logic [31:0]           r_word;
  logic [31:0]           r_tmo;
  logic                  r_ready;
  logic                  r_wr_en;
  logic [31:0]           r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_cpu_rst;
  logic                  r_done;
  logic                  r_err;

  state_t                w_state_nxt;
  logic [1:0]            w_bcnt_nxt;
  logic [c_WIDX_W-1:0]   w_widx_nxt;
  logic [31:0]           w_len_nxt;
  logic [31:0]           w_word_nxt;
  logic [31:0]           w_tmo_nxt;
  logic [31:0]           w_addr_nxt;
  logic [31:0]           w_data_nxt;

  logic                  w_xfer;
  logic                  w_tmo_hit;
  logic [31:0]           w_len_full;
  logic [31:0]           w_word_full;
  logic                  w_len_bad;
  logic                  w_last;
  logic [31:0]           w_word_off;

  // Bytes shift in from the top so the first byte of a group lands in [7:0].
  assign w_xfer      = BYTE_VALID && r_ready;
  assign w_tmo_hit   = (c_TMO != 32'd0) && (r_tmo == c_TMO);
  assign w_len_full  = {BYTE_DATA, r_len[31:8]};
  assign w_word_full = {BYTE_DATA, r_word[31:8]};
  assign w_len_bad   = (w_len_full == 32'd0) || (w_len_full > c_DEPTH);
  assign w_last      = ({{(32-c_WIDX_W){1'b0}}, r_widx} == (r_len - 32'd1));
  assign w_word_off  = {{(30-c_WIDX_W){1'b0}}, r_widx, 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_widx_nxt  = r_widx;
    w_len_nxt   = r_len;
    w_word_nxt  = r_word;
    w_tmo_nxt   = r_tmo;
    w_addr_nxt  = r_wr_addr;
    w_data_nxt  = r_wr_data;

    case (r_state)
      S_IDLE, S_ERR: begin
        if (START) begin
          w_state_nxt = S_LEN;
          w_bcnt_nxt  = 2'd0;
          w_widx_nxt  = '0;
          w_tmo_nxt   = 32'd0;
        end
      end

      S_LEN: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
        end else if (w_xfer) begin
          w_len_nxt  = w_len_full;
          w_bcnt_nxt = r_bcnt + 2'd1;
          w_tmo_nxt  = 32'd0;
          if (r_bcnt == 2'd3) begin
            w_state_nxt = w_len_bad ? S_ERR : S_DATA;
          end
        end else if (c_TMO != 32'd0) begin
          w_tmo_nxt = r_tmo + 32'd1;
        end
      end

      S_DATA: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
        end else if (w_xfer) begin
          w_word_nxt = w_word_full;
          w_bcnt_nxt = r_bcnt + 2'd1;
          w_tmo_nxt  = 32'd0;
          if (r_bcnt == 2'd3) begin
            w_state_nxt = S_WRITE;
            w_addr_nxt  = BASE_ADDR + w_word_off;
            w_data_nxt  = w_word_full;
          end
        end else if (c_TMO != 32'd0) begin
          w_tmo_nxt = r_tmo + 32'd1;
        end
      end

      S_WRITE: begin
        w_widx_nxt = r_widx + c_WIDX_W'(1);
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DATA;
          w_tmo_nxt   = 32'd0;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every output is registered from the next state so it aligns with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_bcnt    <= 2'd0;
      r_widx    <= '0;
      r_len     <= 32'd0;
      r_word    <= 32'd0;
      r_tmo     <= 32'd0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= BASE_ADDR;
      r_wr_data <= 32'd0;
      r_cpu_rst <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_widx    <= w_widx_nxt;
      r_len     <= w_len_nxt;
      r_word    <= w_word_nxt;
      r_tmo     <= w_tmo_nxt;
      r_ready   <= (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA);
      r_wr_en   <= (w_state_nxt == S_WRITE);
      r_wr_addr <= w_addr_nxt;
      r_wr_data <= w_data_nxt;
      r_cpu_rst <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_err     <= (w_state_nxt == S_ERR);
    end
  end

  assign BYTE_READY = r_ready;
  assign WR_EN      = r_wr_en;
  assign WR_ADDR    = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign CPU_RST    = r_cpu_rst;
  assign DONE       = r_done;
  assign ERR        = r_err;

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes instruction words into the OTTER 16384x32 program memory. It is the write-side counterpart of the program ROM's read port. The loader receives a length-prefixed little-endian byte stream through a valid/ready handshake, for example from a UART receiver. It assembles 32-bit words, issues one-cycle word writes at auto-incrementing byte addresses, and holds the CPU in reset for the whole load.

## Interface
Parameters:
- DEPTH, 16384: memory capacity in words; the largest legal word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between accepted bytes during a load; 0 disables the timeout.

Ports:
- CLK, input, 1: single clock.
- RST, input, 1: synchronous, active-high reset.
- START, input, 1: arms a load; honoured only in IDLE or ERR.
- BYTE_VALID, input, 1: BYTE_DATA holds a valid byte.
- BYTE_DATA, input, 8: stream byte.
- BYTE_READY, output, 1: loader accepts a byte this cycle.
- WR_EN, output, 1: program-memory write strobe, one cycle per word.
- WR_ADDR, output, 32: byte address, word-aligned; the memory uses bits [15:2].
- WR_DATA, output, 32: assembled instruction word.
- CPU_RST, output, 1: holds the MCU in reset while loading or in error.
- DONE, output, 1: one-cycle pulse when a load completes.
- ERR, output, 1: sticky error flag.

## Operation
- Handshake: a byte transfers on a rising CLK edge where BYTE_VALID && BYTE_READY. BYTE_READY does not depend combinationally on BYTE_VALID.
- Frame format: 4 length bytes giving word count N, LSB first, then 4*N data bytes. Each word is little-endian: the first byte becomes WR_DATA[7:0].
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: BYTE_READY=0, CPU_RST=0. START=1 moves to LEN, sets CPU_RST=1, clears the byte and word counters and ERR.
- LEN: BYTE_READY=1. Accepts 4 bytes into a 32-bit length register.
  - On the 4th byte, if N==0 or N>DEPTH, go to ERR.
  - Otherwise go to DATA.
- DATA: BYTE_READY=1. Shifts bytes into the word register. The 4th byte moves the FSM to WRITE.
- WRITE: BYTE_READY=0, WR_EN=1 for exactly one cycle.
  - WR_ADDR = BASE_ADDR + 4*word_idx (32-bit, wraps modulo 2^32).
  - word_idx increments. If the word just written was word N-1, go to DONE; otherwise return to DATA.
- DONE: DONE=1 for one cycle, then IDLE. CPU_RST falls on entry to IDLE.
- ERR: ERR=1, CPU_RST=1, BYTE_READY=0. Stays here until START, which moves to LEN.
- START in LEN, DATA, WRITE or DONE is ignored.
- Timeout: in LEN and DATA, a counter increments on every cycle with no transfer and clears on every transfer or state entry. Reaching TIMEOUT_CYCLES moves to ERR. The counter is frozen in WRITE.
- Bytes arriving after a completed frame are not accepted, because BYTE_READY=0 in IDLE.
- The byte counter (2 bits) and word counter (15 bits) are sized so that N=DEPTH does not overflow.

## Timing
- All outputs are registered. Reset values: BYTE_READY=0, WR_EN=0, WR_ADDR=BASE_ADDR, WR_DATA=0, CPU_RST=0, DONE=0, ERR=0, state IDLE.
- START sampled high in cycle t gives CPU_RST=1 and BYTE_READY=1 at t+1.
- 4th byte of a word accepted at edge t: WR_EN, WR_ADDR and WR_DATA are valid in cycle t+1, and BYTE_READY=0 in that same cycle.
  - BYTE_READY returns to 1 at t+2, so peak throughput is 1 word per 5 cycles.
- Last word's WR_EN in cycle t: DONE=1 in cycle t+1, and CPU_RST=0 from cycle t+2.
- Length error: ERR=1 in the cycle after the 4th length byte, and no write is issued.
- Timeout error: ERR=1 in the cycle after the counter reaches TIMEOUT_CYCLES.
- RST mid-load: next cycle returns to reset values and the partial word is discarded. Writes already issued remain in memory.

## Test plan
- BASE_ADDR=0, stream 02 00 00 00 13 00 00 00 B7 12 34 00 -> two WR_EN pulses: (0x0, 0x00000013) then (0x4, 0x003412B7); DONE one cycle later; CPU_RST high from START+1 until DONE+1.
- Same stream with BYTE_VALID toggling 1-0-1-0 -> identical writes; no byte dropped or duplicated; no write while BYTE_VALID low.
- Length 00 00 00 00 -> ERR=1, zero writes, CPU_RST=1. A later START then a valid 1-word frame -> ERR clears, one write, DONE.
- Length 01 40 00 00 (16385) -> ERR; length 00 40 00 00 with 16384 words -> last write at WR_ADDR 0xFFFC, DONE.
- TIMEOUT_CYCLES=8, stop after 2 data bytes -> ERR exactly 9 cycles after the last accepted byte; no WR_EN.
- RST asserted in DATA after 5 of 8 bytes -> all outputs at reset values next cycle. START with a full frame afterwards -> writes restart at BASE_ADDR.
